// File: rtl/alu_sched.sv
// alu_sched
// ---------
// Shares one combinational 16-bit ALU between two requesters.
//   requester 0 : instruction datapath (the only one allowed to update flags)
//   requester 1 : auxiliary address/debug unit
//
// Each transaction takes three states:
//   IDLE : round-robin grant, request accepted on valid&ready
//   EXEC : ALU result captured, flags updated
//   RESP : response held on the output channel until rsp_ready
//
// Handshake rule (same on every channel): a transfer happens on a rising
// clock edge where valid and ready are both high. A producer keeps its
// payload stable while valid is high and ready is low.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req{0,1}_valid/ready        request handshake
//   req{0,1}_op/a/b             request opcode and operands
//   alu_op, alu_in1, alu_in2    registered operands driven to the ALU
//   alu_out, alu_flags          ALU result and {N,V,Z}
//   rsp_valid/ready             response handshake
//   rsp_id, rsp_data, rsp_err   response payload
//   flags_q                     architectural {N,V,Z}
//   dbg_state                   current FSM state (IDLE=0, EXEC=1, RESP=2)

module alu_sched #(
  parameter logic       RR_INIT  = 1'b0,
  parameter logic [2:0] FLAG_RST = 3'b000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic [3:0]  alu_op,
  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  input  logic [15:0] alu_out,
  input  logic [2:0]  alu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic [2:0]  flags_q,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h3;
  localparam logic [3:0] OP_SLL = 4'h4;
  localparam logic [3:0] OP_SRA = 4'h5;
  localparam logic [3:0] OP_ROR = 4'h6;

  state_t      state_q;
  logic        rr_q;        // requester favoured when both are valid
  logic [3:0]  op_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic        id_q;
  logic        rsp_valid_q;
  logic        rsp_id_q;
  logic [15:0] rsp_data_q;
  logic        rsp_err_q;
  logic [2:0]  flags_r;

  logic grant0;
  logic grant1;
  logic acc0;
  logic acc1;
  logic exec_err;
  logic zero_only_op;

  // Grant depends only on state, pointer and valids; never on rsp_ready.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | ~rr_q);
    grant1 = req1_valid & (~req0_valid |  rr_q);
  end

  assign req0_ready = (state_q == IDLE) & grant0;
  assign req1_ready = (state_q == IDLE) & grant1;
  assign acc0       = req0_valid & req0_ready;
  assign acc1       = req1_valid & req1_ready;

  // Opcodes 12..15 have no ALU meaning.
  assign exec_err     = (op_q >= 4'hC);
  assign zero_only_op = (op_q == OP_XOR) | (op_q == OP_SLL) |
                        (op_q == OP_SRA) | (op_q == OP_ROR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= RR_INIT;
      op_q        <= 4'h0;
      a_q         <= 16'h0000;
      b_q         <= 16'h0000;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= 16'h0000;
      rsp_err_q   <= 1'b0;
      flags_r     <= FLAG_RST;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc0 || acc1) begin
            op_q    <= acc0 ? req0_op : req1_op;
            a_q     <= acc0 ? req0_a  : req1_a;
            b_q     <= acc0 ? req0_b  : req1_b;
            id_q    <= acc1;
            // Point at the requester that was not just served.
            rr_q    <= acc0;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_q  <= exec_err ? 16'h0000 : alu_out;
          rsp_err_q   <= exec_err;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          if (!id_q && !exec_err) begin
            if (op_q == OP_ADD || op_q == OP_SUB) begin
              flags_r <= alu_flags;
            end else if (zero_only_op) begin
              // Logic/shift ops refresh Z only; N and V keep their values.
              flags_r[0] <= (alu_out == 16'h0000);
            end
          end
          state_q <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign alu_op    = op_q;
  assign alu_in1   = a_q;
  assign alu_in2   = b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign flags_q   = flags_r;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_sched.sv
module tb_alu_sched;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op, alu_op;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [15:0] alu_in1, alu_in2, alu_out, rsp_data;
  logic [2:0]  alu_flags, flags_q;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [1:0]  dbg_state;

  alu_sched #(.RR_INIT(1'b0), .FLAG_RST(3'b000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .alu_op     (alu_op),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_out    (alu_out),
    .alu_flags  (alu_flags),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .flags_q    (flags_q),
    .dbg_state  (dbg_state)
  );

  // ---------------- ALU model ----------------
  // Ops other than ADD/SUB report flags 3'b101 so that a scheduler copying
  // alu_flags for them would be visible.
  always_comb begin
    alu_out   = alu_in1 + alu_in2;
    alu_flags = 3'b101;
    case (alu_op)
      4'h0: begin
        alu_out   = alu_in1 + alu_in2;
        alu_flags = {alu_out[15],
                     (alu_in1[15] == alu_in2[15]) && (alu_out[15] != alu_in1[15]),
                     alu_out == 16'h0000};
      end
      4'h1: begin
        alu_out   = alu_in1 - alu_in2;
        alu_flags = {alu_out[15],
                     (alu_in1[15] != alu_in2[15]) && (alu_out[15] != alu_in1[15]),
                     alu_out == 16'h0000};
      end
      4'h3: alu_out = alu_in1 ^ alu_in2;
      4'h4: alu_out = alu_in1 << alu_in2[3:0];
      4'h5: alu_out = $unsigned($signed(alu_in1) >>> alu_in2[3:0]);
      4'h6: alu_out = (alu_in1 >> alu_in2[3:0]) | (alu_in1 << (5'd16 - {1'b0, alu_in2[3:0]}));
      default: alu_out = alu_in1 + alu_in2;
    endcase
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [17:0] exp_q[$];   // {id, err, data}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_rsp(input logic [2:0] exp_flags);
    logic [17:0] e;
    check("rsp_valid", rsp_valid, 1);
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("rsp_id",   rsp_id,   e[17]);
      check("rsp_err",  rsp_err,  e[16]);
      check("rsp_data", rsp_data, e[15:0]);
    end
    check("flags", flags_q, exp_flags);
  endtask

  // ---------------- drivers ----------------
  task automatic scramble_inputs();
    req0_op = 4'($urandom_range(0, 15));
    req1_op = 4'($urandom_range(0, 15));
    req0_a  = 16'($urandom_range(0, 65535));
    req0_b  = 16'($urandom_range(0, 65535));
    req1_a  = 16'($urandom_range(0, 65535));
    req1_b  = 16'($urandom_range(0, 65535));
  endtask

  task automatic drive_req(input bit port, input logic [3:0] op,
                           input logic [15:0] a, input logic [15:0] b);
    if (!port) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  // One full transaction with rsp_ready high; returns at the RESP-cycle negedge.
  task automatic run_req(input bit port, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp_data,
                         input bit exp_err, input logic [2:0] exp_flags);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drive_req(port, op, a, b);
    @(negedge clk);
    check("ready", port ? req1_ready : req0_ready, 1);
    exp_q.push_back({port, exp_err, exp_data});
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    scramble_inputs();
    @(negedge clk);
    check("exec_no_rsp", rsp_valid, 0);
    @(negedge clk);
    check_rsp(exp_flags);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    req0_op = '0; req1_op = '0; req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data",  rsp_data,  0);
    check("rst_rsp_id",    rsp_id,    0);
    check("rst_rsp_err",   rsp_err,   0);
    check("rst_flags",     flags_q,   3'b000);
    check("rst_alu",       {alu_op, alu_in1, alu_in2}, 0);
    check("rst_ready",     {req0_ready, req1_ready}, 0);

    // Single request: 3 + 4
    run_req(1'b0, 4'h0, 16'h0003, 16'h0004, 16'h0007, 1'b0, 3'b000);

    // Contention from a fresh reset: grants 0,1,0,1, one accept per 3 cycles
    do_reset();
    @(posedge clk); #1;
    drive_req(1'b0, 4'h0, 16'h0100, 16'h0023);   // ADD -> 0x0123
    drive_req(1'b1, 4'h3, 16'h00FF, 16'h0F0F);   // XOR -> 0x0FF0
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("cont_ready0", req0_ready, (k % 2) == 0);
      check("cont_ready1", req1_ready, (k % 2) == 1);
      exp_q.push_back((k % 2) == 0 ? {1'b0, 1'b0, 16'h0123} : {1'b1, 1'b0, 16'h0FF0});
      @(negedge clk);
      check("cont_exec_ready", {req0_ready, req1_ready}, 0);
      @(negedge clk);
      check_rsp(3'b000);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Flags
    run_req(1'b0, 4'h1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 3'b010);
    run_req(1'b1, 4'h1, 16'h0005, 16'h0005, 16'h0000, 1'b0, 3'b010);
    run_req(1'b0, 4'h3, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b0, 3'b011);

    // Illegal opcodes
    run_req(1'b1, 4'hE, 16'h0001, 16'h0002, 16'h0000, 1'b1, 3'b011);
    run_req(1'b0, 4'hC, 16'h0001, 16'h0002, 16'h0000, 1'b1, 3'b011);

    // Async reset in the middle of EXEC
    @(posedge clk); #1;
    drive_req(1'b0, 4'h0, 16'h7FFF, 16'h0001);
    @(negedge clk);
    check("mid_ready", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    check("mid_in_exec", dbg_state, 2'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_state", dbg_state, 2'd0);
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_flags", flags_q, 3'b000);
    check("mid_rst_alu",   {alu_op, alu_in1, alu_in2}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("mid_no_rsp", rsp_valid, 0);
    end
    run_req(1'b0, 4'h0, 16'h0003, 16'h0004, 16'h0007, 1'b0, 3'b000);

    // Backpressure: hold the response for 5 cycles while req1 waits
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    drive_req(1'b0, 4'h0, 16'h0001, 16'h0002);
    @(negedge clk);
    check("bp_ready0", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    drive_req(1'b1, 4'h0, 16'h0010, 16'h0020);
    @(negedge clk);
    check("bp_exec_ready1", req1_ready, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", rsp_valid, 1);
      check("bp_data",  rsp_data,  16'h0003);
      check("bp_id",    rsp_id,    0);
      check("bp_ready", {req0_ready, req1_ready}, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_ready1", req1_ready, 0);
    @(negedge clk);
    check("bp_resume_ready1", req1_ready, 1);
    exp_q.push_back({1'b1, 1'b0, 16'h0030});
    @(posedge clk); #1;
    req1_valid = 1'b0;
    scramble_inputs();
    @(negedge clk);
    @(negedge clk);
    check_rsp(3'b000);

    @(posedge clk); #1;
    @(negedge clk);
    check("end_idle", dbg_state, 2'd0);
    check("end_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_sched.md
# alu_sched

Two-port scheduler that shares the single 16-bit ALU (ADD/SUB/RED/XOR/SLL/SRA/ROR/PADDSB/LW/SW/LHB/LLB opcodes) between requester 0 (the instruction datapath) and requester 1 (the auxiliary address/debug unit). It accepts requests over a valid/ready handshake and arbitrates round-robin. It drives the ALU from registered operands, captures the result, and returns it over a valid/ready response channel. It also owns the architectural N/V/Z flag register, which only requester 0 may update.

## Interface
- RR_INIT, 1'b0, requester favoured by round-robin after reset (0 or 1)
- FLAG_RST, 3'b000, reset value of flag register {N,V,Z}

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
- req0_op / req1_op  in  4  ALU opcode
- req0_a / req1_a  in  16  operand 1
- req0_b / req1_b  in  16  operand 2
- alu_op  out  4  opcode to ALU
- alu_in1 / alu_in2  out  16  operands to ALU
- alu_out  in  16  ALU result (combinational from alu_op/alu_in*)
- alu_flags  in  3  ALU {N,V,Z}
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that owns the response
- rsp_data  out  16  captured result
- rsp_err  out  1  opcode was not an ALU opcode (12–15)
- flags_q  out  3  architectural {N,V,Z}

## Operation
- FSM states are IDLE, EXEC and RESP. Reset enters IDLE.
- IDLE grant:
  - Only one valid: grant it.
  - Both valid: grant the requester indicated by the RR pointer.
  - reqN_ready = (state==IDLE) & grantN. At most one ready is high, and only when that requester is valid.
- Accept (valid&ready):
  - Latch op, a, b and id into the operand registers. Go to EXEC.
  - Set the RR pointer to the other requester. The pointer does not change on cycles with no accept.
- alu_op, alu_in1 and alu_in2 are driven directly from the operand registers at all times.
- EXEC is one cycle:
  - Capture alu_out into rsp_data.
  - Set rsp_err = (op ≥ 4'hC). When rsp_err is set, rsp_data = 16'h0000.
  - Go to RESP.
- Flag update in EXEC, only when id==0 and rsp_err==0:
  - ADD (0000) or SUB (0001): flags_q <= alu_flags.
  - XOR, SLL, SRA, ROR: flags_q[0] <= (alu_out==16'h0000). N and V hold.
  - All other opcodes: flags hold.
  - Requester 1 never changes flags_q.
- RESP:
  - rsp_valid=1. rsp_id, rsp_data and rsp_err are stable until handshake.
  - On rsp_ready go to IDLE. Otherwise hold.
- rst_n low at any time, including mid-EXEC or mid-RESP: immediate return to IDLE. The in-flight transaction is dropped and no flag update occurs.

## Timing
- Reset values:
  - All outputs low. rsp_data = 0. flags_q = FLAG_RST.
  - Operand registers zero, so alu_op = 0 and alu_in* = 0.
  - RR pointer = RR_INIT.
- Accept at edge T. EXEC during cycle T+1. rsp_valid high from T+2.
- Minimum issue interval is 3 cycles. The next accept is possible at the edge that ends the RESP handshake cycle +1, i.e. ready is high only in IDLE.
- flags_q changes at the end of the EXEC cycle. The response and the new flags become visible in the same cycle.
- rsp_ready held high: IDLE→EXEC→RESP→IDLE, one response every 3 cycles.
- ready is combinational from state, RR pointer and valids. It has no dependency on rsp_ready.
- Requester inputs are don't-care except in the IDLE accept cycle.

## Test plan
- Reset then single request: req0 ADD a=16'h0003 b=16'h0004 -> req0_ready in cycle 0, rsp_valid at +2 with rsp_data=16'h0007, rsp_id=0, rsp_err=0; flags_q=3'b000.
- Contention: req0 and req1 valid continuously, RR_INIT=0, rsp_ready=1 -> grants alternate 0,1,0,1; accepts every 3 cycles; rsp_id sequence matches.
- Flags: req0 SUB 16'h8000-16'h0001 -> V=1; then req1 SUB 5-5 -> flags_q unchanged; then req0 XOR 16'hAAAA^16'hAAAA -> Z=1, N and V unchanged.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_data and rsp_id stable; both ready low; accept resumes the cycle after handshake+IDLE.
- Illegal opcode: req1 op=4'hE -> rsp_err=1, rsp_data=16'h0000, flags unchanged.
- Async reset asserted mid-EXEC of a req0 ADD -> outputs zero immediately, flags_q=FLAG_RST, no response after release, next request served normally.
